writeback_stage: RTL and testbench

MEM/WB pipeline latch and writeback selector of the pipelined datapath. It sits directly upstream of `register_file`. It captures the memory-stage result on the rising edge and drives `WEN`/`wsel`/`wdat` into the register file write port, which commits on the following falling edge. It also owns halt sequencing and an optional retired-instruction counter.

---
 rtl/cpu_types_pkg.sv | 36 +++
 rtl/wb_mux.sv | 25 ++
 rtl/writeback_stage.sv | 95 +++++++++
 tb/tb_writeback_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared datapath types: word/register widths plus the MEM/WB latch layout,
// writeback source encoding and writeback-stage FSM states.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_NPC  = 2'b10,
        WB_LUI  = 2'b11
    } wbsrc_t;

    typedef enum logic {
        WB_RUN    = 1'b0,
        WB_HALTED = 1'b1
    } wbstate_t;

    typedef struct packed {
        logic        valid;
        logic        regwen;
        regbits_t    wsel;
        wbsrc_t      wbsrc;
        word_t       aluout;
        word_t       dload;
        word_t       npc;
        logic [15:0] imm16;
        logic        halt_i;
        logic        fresh;
    } mem_wb_t;

endpackage

// File: rtl/wb_mux.sv
// Writeback data selector; purely combinational so the forwarding unit can
// reuse it to produce the same value the register file will see.
module wb_mux
    import cpu_types_pkg::*;
(
    input  wbsrc_t      wbsrc,
    input  word_t       aluout,
    input  word_t       dload,
    input  word_t       npc,
    input  logic [15:0] imm16,
    output word_t       wdat
);

    always_comb begin
        wdat = aluout;
        case (wbsrc)
            WB_ALU:  wdat = aluout;
            WB_LOAD: wdat = dload;
            WB_NPC:  wdat = npc;
            WB_LUI:  wdat = {imm16, 16'h0000};
            default: wdat = aluout;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB latch, writeback port drive and sticky halt sequencing.
// Define WB_RETIRE_CNT_EN to build the retired-instruction counter and port.
module writeback_stage
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_valid,
    input  logic        mem_regwen,
    input  regbits_t    mem_wsel,
    input  wbsrc_t      mem_wbsrc,
    input  word_t       mem_aluout,
    input  word_t       mem_dload,
    input  word_t       mem_npc,
    input  logic [15:0] mem_imm16,
    input  logic        mem_halt,
    output logic        WEN,
    output regbits_t    wsel,
    output word_t       wdat,
    output logic        halt
`ifdef WB_RETIRE_CNT_EN
    ,
    output word_t       retired
`endif
);

    mem_wb_t  wb_reg;
    wbstate_t state_reg;
    logic     halt_in_wb;

    assign halt_in_wb = wb_reg.valid & wb_reg.halt_i;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wb_reg    <= '0;
            state_reg <= WB_RUN;
        end else if (state_reg == WB_RUN) begin
            if (halt_in_wb)
                state_reg <= WB_HALTED;
            if (flush) begin
                wb_reg.valid  <= 1'b0;
                wb_reg.regwen <= 1'b0;
                wb_reg.halt_i <= 1'b0;
            end else if (stall) begin
                // Holding: the instruction has been seen once already.
                wb_reg.fresh  <= 1'b0;
            end else begin
                wb_reg <= '{valid:  mem_valid,
                            regwen: mem_regwen,
                            wsel:   mem_wsel,
                            wbsrc:  mem_wbsrc,
                            aluout: mem_aluout,
                            dload:  mem_dload,
                            npc:    mem_npc,
                            imm16:  mem_imm16,
                            halt_i: mem_halt,
                            fresh:  mem_valid};
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    word_t retired_reg;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            retired_reg <= '0;
        else if (state_reg == WB_RUN && wb_reg.valid && wb_reg.fresh)
            retired_reg <= retired_reg + 32'd1;
    end

    assign retired = retired_reg;
`else
    logic unused_fresh;
    assign unused_fresh = wb_reg.fresh;
`endif

    wb_mux u_wb_mux (
        .wbsrc  (wb_reg.wbsrc),
        .aluout (wb_reg.aluout),
        .dload  (wb_reg.dload),
        .npc    (wb_reg.npc),
        .imm16  (wb_reg.imm16),
        .wdat   (wdat)
    );

    // r0 is hardwired zero, so a write to it is never requested.
    assign WEN  = wb_reg.valid & wb_reg.regwen & (wb_reg.wsel != '0)
                & (state_reg == WB_RUN) & ~wb_reg.halt_i;
    assign wsel = wb_reg.wsel;
    assign halt = (state_reg == WB_HALTED) | halt_in_wb;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized + directed bench for writeback_stage against a record-level model.
module tb_writeback_stage;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        stall, flush, mem_valid, mem_regwen, mem_halt;
    logic [4:0]  mem_wsel;
    wbsrc_t      mem_wbsrc;
    logic [31:0] mem_aluout, mem_dload, mem_npc;
    logic [15:0] mem_imm16;
    logic        WEN, halt;
    logic [4:0]  wsel;
    logic [31:0] wdat;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    writeback_stage dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .stall      (stall),
        .flush      (flush),
        .mem_valid  (mem_valid),
        .mem_regwen (mem_regwen),
        .mem_wsel   (mem_wsel),
        .mem_wbsrc  (mem_wbsrc),
        .mem_aluout (mem_aluout),
        .mem_dload  (mem_dload),
        .mem_npc    (mem_npc),
        .mem_imm16  (mem_imm16),
        .mem_halt   (mem_halt),
        .WEN        (WEN),
        .wsel       (wsel),
        .wdat       (wdat),
        .halt       (halt)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retired    (retired)
`endif
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    endtask

    // Model: the instruction currently in WB, whether it has been counted,
    // whether the machine has halted, and how many instructions retired.
    typedef struct {
        logic        valid, regwen, hlt, counted;
        logic [4:0]  ws;
        logic [1:0]  src;
        logic [31:0] alu, dl, np;
        logic [15:0] imm;
    } instr_t;

    instr_t      m;
    logic        m_halted;
    logic [31:0] m_count;

    function automatic logic [31:0] value_of(input instr_t i);
        case (i.src)
            2'd0:    return i.alu;
            2'd1:    return i.dl;
            2'd2:    return i.np;
            default: return {i.imm, 16'h0000};
        endcase
    endfunction

    always @(posedge CLK) begin
        logic halting;
        logic exp_wen;
        #1;
        if (!nRST) begin
            m = '{default: '0};
            m_halted = 1'b0;
            m_count  = '0;
        end else if (!m_halted) begin
            halting = m.valid && m.hlt;
            if (m.valid && !m.counted) begin
                m_count   = m_count + 32'd1;
                m.counted = 1'b1;
            end
            if (flush) begin
                m.valid = 1'b0; m.regwen = 1'b0; m.hlt = 1'b0;
            end else if (!stall) begin
                m.valid = mem_valid; m.regwen = mem_regwen; m.ws = mem_wsel;
                m.src = mem_wbsrc; m.alu = mem_aluout; m.dl = mem_dload;
                m.np = mem_npc; m.imm = mem_imm16; m.hlt = mem_halt;
                m.counted = 1'b0;
            end
            if (halting) m_halted = 1'b1;
        end
        exp_wen = !m_halted && m.valid && m.regwen && (m.ws != 0) && !m.hlt;
        check("cyc_wen",  {31'd0, WEN}, {31'd0, exp_wen});
        check("cyc_wsel", {27'd0, wsel}, {27'd0, m.ws});
        check("cyc_wdat", wdat, value_of(m));
        check("cyc_halt", {31'd0, halt}, {31'd0, m_halted || (m.valid && m.hlt)});
`ifdef WB_RETIRE_CNT_EN
        check("cyc_retired", retired, m_count);
`endif
    end

    task automatic drive(input logic v, input logic rw, input logic [4:0] ws,
                         input logic [1:0] src, input logic [31:0] alu,
                         input logic [31:0] dl, input logic [31:0] np,
                         input logic [15:0] imm, input logic h,
                         input logic st, input logic fl);
        @(negedge CLK);
        mem_valid = v; mem_regwen = rw; mem_wsel = ws; mem_wbsrc = wbsrc_t'(src);
        mem_aluout = alu; mem_dload = dl; mem_npc = np; mem_imm16 = imm;
        mem_halt = h; stall = st; flush = fl;
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nRST = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b0;
        stall = 0; flush = 0; mem_valid = 0; mem_regwen = 0; mem_halt = 0;
        mem_wsel = 0; mem_wbsrc = WB_ALU; mem_aluout = 0; mem_dload = 0;
        mem_npc = 0; mem_imm16 = 0;
        #3;
        check("rst_wen",  {31'd0, WEN}, 32'd0);
        check("rst_wsel", {27'd0, wsel}, 32'd0);
        check("rst_wdat", wdat, 32'd0);
        check("rst_halt", {31'd0, halt}, 32'd0);
`ifdef WB_RETIRE_CNT_EN
        check("rst_retired", retired, 32'd0);
`endif
        @(negedge CLK);
        nRST = 1'b1;

        // Source mux and write-enable gating
        drive(1, 1, 5, 0, 32'h1234, 32'h0, 32'h0, 16'h0, 0, 0, 0); step();
        check("alu_wen",  {31'd0, WEN}, 32'd1);
        check("alu_wsel", {27'd0, wsel}, 32'd5);
        check("alu_wdat", wdat, 32'h1234);
        drive(1, 1, 3, 1, 32'h1, 32'hDEADBEEF, 32'h0, 16'h0, 0, 0, 0); step();
        check("load_wdat", wdat, 32'hDEADBEEF);
        drive(1, 1, 31, 2, 32'h1, 32'h2, 32'h40, 16'h0, 0, 0, 0); step();
        check("npc_wdat", wdat, 32'h40);
        check("npc_wsel", {27'd0, wsel}, 32'd31);
        drive(1, 1, 2, 3, 32'h1, 32'h2, 32'h3, 16'hABCD, 0, 0, 0); step();
        check("lui_wdat", wdat, 32'hABCD0000);
        drive(1, 1, 0, 0, 32'h77, 32'h0, 32'h0, 16'h0, 0, 0, 0); step();
        check("r0_wen", {31'd0, WEN}, 32'd0);
        drive(0, 1, 4, 0, 32'h77, 32'h0, 32'h0, 16'h0, 0, 0, 0); step();
        check("bubble_wen", {31'd0, WEN}, 32'd0);

        // Stall holds outputs four cycles and retires once
        do_reset();
        drive(1, 1, 6, 0, 32'hCAFE, 32'h0, 32'h0, 16'h0, 0, 0, 0); step();
        check("stall_wen0", {31'd0, WEN}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            drive(1, 1, 9, 1, 32'h5, 32'h6, 32'h7, 16'h8, 0, 1, 0); step();
            check($sformatf("stall_wen%0d", i), {31'd0, WEN}, 32'd1);
            check($sformatf("stall_wdat%0d", i), wdat, 32'hCAFE);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
`ifdef WB_RETIRE_CNT_EN
        check("stall_retired", retired, 32'd1);
`endif
        drive(1, 1, 8, 0, 32'h99, 0, 0, 0, 0, 0, 0); step();
        drive(1, 1, 8, 0, 32'h98, 0, 0, 0, 0, 1, 1); step();
        check("stallflush_wen", {31'd0, WEN}, 32'd0);

        // Randomized epochs, each starting from reset
        for (int e = 0; e < 6; e++) begin
            do_reset();
            for (int c = 0; c < 250; c++) begin
                drive(($urandom_range(3, 0) != 0), $urandom_range(1, 0),
                      5'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
                      16'($urandom), ($urandom_range(49, 0) == 0),
                      ($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0));
            end
        end

        // Async reset takes effect between edges
        do_reset();
        drive(1, 1, 5, 0, 32'h1234, 0, 0, 0, 0, 0, 0); step();
        check("async_pre_wen", {31'd0, WEN}, 32'd1);
        #1 nRST = 1'b0;
        #1;
        check("async_wen",  {31'd0, WEN}, 32'd0);
        check("async_wdat", wdat, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;

        // Halt sequencing
        do_reset();
        drive(1, 1, 9, 0, 32'h11, 0, 0, 0, 0, 0, 0); step();
        drive(1, 1, 3, 0, 32'h22, 0, 0, 0, 1, 0, 0); step();
        check("halt_rise", {31'd0, halt}, 32'd1);
        check("halt_wen",  {31'd0, WEN}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 7, 0, 32'h33 + i, 0, 0, 0, 0, i[0], 0); step();
            check("halted_wen",  {31'd0, WEN}, 32'd0);
            check("halted_halt", {31'd0, halt}, 32'd1);
`ifdef WB_RETIRE_CNT_EN
            check("halted_retired", retired, 32'd2);
`endif
        end
        drive(1, 1, 7, 0, 32'h44, 0, 0, 0, 0, 0, 0);
        #1 nRST = 1'b0;
        #1;
        check("halt_rst_halt", {31'd0, halt}, 32'd0);
`ifdef WB_RETIRE_CNT_EN
        check("halt_rst_retired", retired, 32'd0);
`endif
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        step();
        check("post_rst_wen", {31'd0, WEN}, 32'd1);
        check("post_rst_wsel", {27'd0, wsel}, 32'd7);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
